// File: rtl/meas_seq_if.sv
// Signal bundle between the measurement sequencer and its UART RX/TX pair,
// sum/counter datapath and result byte-select mux.
interface meas_seq_if #(
  parameter int CH_W  = 2,
  parameter int SEL_W = 2
) ();
  // Handshakes: rx_ready and tx_send are single-cycle strobes that qualify
  // rx_data / send_sel in that cycle only. sum_ready is a level, honoured only
  // while the sequencer is measuring. tx_busy is a level that stalls the next
  // tx_send. No flow control exists on rx, so a command is accepted every
  // time rx_ready is high.
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             sum_ready;
  logic             tx_busy;
  logic             sum_en;
  logic [CH_W-1:0]  ch_sel;
  logic             tx_send;
  logic [SEL_W-1:0] send_sel;
  logic             cont_mode;
  logic             cmd_err;

  modport master (
    input  rx_ready, rx_data, sum_ready, tx_busy,
    output sum_en, ch_sel, tx_send, send_sel, cont_mode, cmd_err
  );

  modport slave (
    output rx_ready, rx_data, sum_ready, tx_busy,
    input  sum_en, ch_sel, tx_send, send_sel, cont_mode, cmd_err
  );
endinterface

// File: rtl/meas_seq_controller.sv
// Command decoder and measurement/transmit sequencer for the ring-oscillator
// temperature sensor: single-shot or continuous measure, then a paced byte frame.
module meas_seq_controller #(
  parameter int NUM_BYTES  = 3,
  parameter int SEL_W      = 2,
  parameter int CH_W       = 2,
  parameter int GAP_CYCLES = 100,
  parameter int TIMER_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  meas_seq_if.master  bus,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;

  localparam logic [SEL_W-1:0]   LAST_IDX = SEL_W'(NUM_BYTES - 1);
  localparam logic [TIMER_W-1:0] GAP_VAL  = TIMER_W'(GAP_CYCLES);

  logic [2:0]         state, state_nxt;
  logic [1:0]         cmd_op;
  logic [CH_W-1:0]    cmd_ch;
  logic               pending;
  logic [SEL_W-1:0]   idx;
  logic [TIMER_W-1:0] timer;
  logic [CH_W-1:0]    ch_sel_q;
  logic               cont_q;
  logic               gap_done;
  logic               last_byte;

  assign gap_done  = (timer >= GAP_VAL) && !bus.tx_busy;
  assign last_byte = (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.rx_ready || pending) state_nxt = S_DECODE;
      S_DECODE: begin
        case (cmd_op)
          2'b00, 2'b01: state_nxt = S_MEASURE;
          2'b10:        state_nxt = S_IDLE;
          default:      state_nxt = cont_q ? S_MEASURE : S_IDLE;
        endcase
      end
      // A new command aborts the measurement even if the result is ready.
      S_MEASURE: begin
        if (bus.rx_ready || pending) state_nxt = S_DECODE;
        else if (bus.sum_ready)      state_nxt = S_SEND;
      end
      S_SEND:    state_nxt = S_WAIT_TX;
      S_WAIT_TX: begin
        if (gap_done) begin
          if (!last_byte)  state_nxt = S_SEND;
          else if (pending) state_nxt = S_DECODE;
          else if (cont_q)  state_nxt = S_MEASURE;
          else              state_nxt = S_IDLE;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cmd_op   <= 2'b00;
      cmd_ch   <= '0;
      pending  <= 1'b0;
      idx      <= '0;
      timer    <= '0;
      ch_sel_q <= '0;
      cont_q   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state) timer <= '0;
      else if (timer != '1)   timer <= timer + TIMER_W'(1);

      if (bus.rx_ready) begin
        cmd_op <= bus.rx_data[7:6];
        cmd_ch <= bus.rx_data[CH_W-1:0];
      end

      // IDLE and MEASURE go straight to DECODE, so only other states defer.
      if (bus.rx_ready && state != S_IDLE && state != S_MEASURE) pending <= 1'b1;
      else if (state == S_DECODE)                                 pending <= 1'b0;

      if (state == S_DECODE) begin
        if (!cmd_op[1]) begin
          ch_sel_q <= cmd_ch;
          cont_q   <= cmd_op[0];
        end else if (!cmd_op[0]) begin
          cont_q   <= 1'b0;
        end
      end

      if (state == S_MEASURE)                                  idx <= '0;
      else if (state == S_WAIT_TX && gap_done && !last_byte)   idx <= idx + SEL_W'(1);
    end
  end

  assign bus.sum_en    = (state == S_MEASURE);
  assign bus.tx_send   = (state == S_SEND);
  assign bus.send_sel  = (state == S_SEND || state == S_WAIT_TX) ? idx : '0;
  assign bus.cmd_err   = (state == S_DECODE) && (cmd_op == 2'b11);
  assign bus.ch_sel    = ch_sel_q;
  assign bus.cont_mode = cont_q;
  assign state_dbg     = state;

endmodule
